// File: rtl/ex_div.sv
// ex_div: 32-step restoring divider for DIV/DIVU in EX; stalls the front end while busy.
// Define DIV_SIGNED_EN to enable signed DIV; without it every operation is unsigned.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        ex_adv,
    input  logic        refresh,
    output logic        div_stall,
    output logic        div_done,
    output logic [31:0] div_q,
    output logic [31:0] div_r
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] cnt;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvsr;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_r;

    logic          start;
    logic          step;
    logic          last;

    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W:0]    rem_sh;
    logic          ge;
    logic [W-1:0]  quo_nxt;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  fin_q;
    logic [W-1:0]  fin_r;

    assign start = (state == IDLE) && div_req && !refresh;
    assign step  = (state == BUSY) && !refresh;
    assign last  = (cnt == LAST_STEP);

`ifdef DIV_SIGNED_EN
    logic neg_a;
    logic neg_b;
    logic q_neg;
    logic r_neg;

    // Operands are latched as magnitudes; signs are reapplied on the last step.
    assign neg_a = div_signed & div_a[W-1];
    assign neg_b = div_signed & div_b[W-1];
    assign op_a  = neg_a ? (~div_a + W'(1)) : div_a;
    assign op_b  = neg_b ? (~div_b + W'(1)) : div_b;
    assign fin_q = q_neg ? (~quo_nxt + W'(1)) : quo_nxt;
    assign fin_r = r_neg ? (~rem_nxt + W'(1)) : rem_nxt;
`else
    logic unused_signed;

    assign unused_signed = div_signed;
    assign op_a  = div_a;
    assign op_b  = div_b;
    assign fin_q = quo_nxt;
    assign fin_r = rem_nxt;
`endif

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        rem_sh  = {rem, quo[W-1]};
        ge      = (rem_sh >= {1'b0, dvsr});
        rem_nxt = ge ? W'(rem_sh - {1'b0, dvsr}) : rem_sh[W-1:0];
        quo_nxt = {quo[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (refresh) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (div_req) state_nxt = BUSY;
                BUSY:    if (last)    state_nxt = DONE;
                DONE:    if (ex_adv)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stall/done are combinational so a flush or reset cancels them in the same cycle.
    always_comb begin
        div_stall = 1'b0;
        div_done  = 1'b0;
        div_q     = '0;
        div_r     = '0;
        if (!rst) begin
            div_q = res_q;
            div_r = res_r;
            if (!refresh) begin
                case (state)
                    IDLE:    div_stall = div_req;
                    BUSY:    div_stall = 1'b1;
                    DONE:    div_done  = 1'b1;
                    default: div_stall = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            res_q <= '0;
            res_r <= '0;
`ifdef DIV_SIGNED_EN
            q_neg <= 1'b0;
            r_neg <= 1'b0;
`endif
        end else if (start) begin
            cnt   <= '0;
            quo   <= op_a;
            rem   <= '0;
            dvsr  <= op_b;
`ifdef DIV_SIGNED_EN
            // A zero divisor keeps the all-ones quotient unnegated.
            q_neg <= (neg_a ^ neg_b) & (|div_b);
            r_neg <= neg_a;
`endif
        end else if (step) begin
            cnt <= cnt + CW'(1);
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (last) begin
                res_q <= fin_q;
                res_r <= fin_r;
            end
        end
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  Pipeline clock; all state changes on the rising edge.
REQ-003 rst  input  1  Synchronous active-high reset.
REQ-004 div_req  input  1  EX stage holds a valid DIV/DIVU instruction.
REQ-005 div_signed  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 div_a  input  32  Dividend (EX rs operand after forwarding).
REQ-007 div_b  input  32  Divisor (EX rt operand after forwarding).
REQ-008 ex_adv  input  1  EX instruction leaves EX this cycle (inverse of id_ex_stall from the hazard unit).
REQ-009 refresh  input  1  EX flush (exception or ex_mem_refresh); aborts any operation.
REQ-010 div_stall  output  1  Stall request to the hazard unit; holds IF/ID/EX while 1.
REQ-011 div_done  output  1  Quotient and remainder valid for the EX instruction.
REQ-012 div_q  output  32  Quotient, destined for LO.
REQ-013 div_r  output  32  Remainder, destined for HI.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 IDLE: if div_req && !refresh, it SHALL latch |a| and |b| (raw values when unsigned), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]), clear the 6-bit counter, and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-016 BUSY: each cycle SHALL perform one restoring shift-subtract step and increment the counter; after the 32nd step the FSM SHALL go to DONE.
REQ-017 Latency: a request first seen in cycle N SHALL assert div_done in cycle N+33.
REQ-018 div_stall SHALL be combinational: 1 in IDLE when div_req && !refresh, 1 in BUSY, 0 in DONE.
REQ-019 DONE: div_done SHALL be 1, and div_q/div_r SHALL hold the sign-corrected result and stay stable.
REQ-020 DONE SHALL go to IDLE on ex_adv; otherwise it SHALL stay in DONE, so that an external stall does not restart the same instruction.
REQ-021 Back-to-back divides: a new div_req in the IDLE cycle after DONE SHALL start a new operation.
REQ-022 Sign correction: the quotient SHALL be negated when the quotient sign is 1; the remainder SHALL be negated when the remainder sign is 1 (signed mode only).
REQ-023 Divisor zero SHALL give div_q = 32'hFFFFFFFF and div_r = div_a as latched, in full latency, with no exception.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give div_q = 0x80000000 and div_r = 0.
REQ-025 refresh SHALL take priority in every state: in the same cycle it SHALL force div_stall = 0 and div_done = 0, and the next state SHALL be IDLE.
REQ-026 div_q and div_r SHALL be don't-care outside DONE; the bench SHALL check them only when div_done = 1.

Reset
REQ-027 While rst = 1, the state SHALL be IDLE, the counter 0, the internal registers 0, and div_stall, div_done, div_q and div_r all 0.
REQ-028 rst asserted mid-operation (BUSY or DONE) SHALL abandon it; the first cycle after rst deasserts SHALL be IDLE, and div_req SHALL be sampled fresh.

Configuration
REQ-029 Macro DIV_SIGNED_EN defined: signed division SHALL follow REQ-015, REQ-022 and REQ-024.
REQ-030 Macro DIV_SIGNED_EN undefined: div_signed SHALL be ignored, every operation SHALL be unsigned, and the absolute-value and negation logic SHALL be omitted.

Verification
REQ-031 Unsigned 100/7, div_req held, ex_adv = 1 at DONE -> div_stall = 1 for cycles N..N+32; div_done in N+33 with q = 14, r = 2; IDLE in N+34.
REQ-032 Signed -7/2 (0xFFFFFFF9 / 2) -> q = 0xFFFFFFFD, r = 0xFFFFFFFF; signed 0x80000000 / -1 -> q = 0x80000000, r = 0.
REQ-033 Divisor 0, a = 0x1234 -> after 33 cycles q = 0xFFFFFFFF, r = 0x1234.
REQ-034 refresh pulsed in BUSY cycle N+10 -> div_stall = 0 that cycle, no div_done, IDLE in N+11; a new request in N+11 completes in N+44.
REQ-035 ex_adv = 0 for 3 cycles in DONE -> div_done and the results stay stable and no restart occurs; ex_adv = 1 -> IDLE; an immediate second div_req -> a fresh 33-cycle operation.
REQ-036 rst asserted in BUSY cycle N+5 -> all outputs 0 next cycle; a request after reset completes normally.
